pu_io_initiator: RTL and testbench

- Per-PU initiator for the shared PU memory request/acknowledge interface (`io_req`/`io_cmd`/`io_ack`/`io_ack_data`).
- Accepts one core load/store/atomic request at a time, issues it as a single-cycle `io_req` pulse, and waits for the matching `io_ack`.
- Returns the response data, or a timeout error, to the core.
- One instance per PU, between the PU load/store unit and the multi-PU memory responders (topic PD memory and peers).

---
 rtl/pu_io_initiator.sv | 100 ++++++++++
 tb/tb_pu_io_initiator.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pu_io_initiator.sv
// pu_io_initiator: per-PU single-outstanding request/ack initiator with ack timeout.
package pu_io_pkg;
  localparam int PU_WIDTH_NBITS = 32;
  localparam int TID_NBITS = 4;
  localparam int ADDR_NBITS = 32;
  typedef struct packed {
    logic [TID_NBITS-1:0] tid;
    logic [ADDR_NBITS-1:0] addr;
    logic [PU_WIDTH_NBITS-1:0] wdata;
    logic wr;
    logic atomic;
    logic [4:0] funct5;
  } io_type;
endpackage

module pu_io_initiator
  import pu_io_pkg::*;
#(
  parameter int WIDTH_NBITS = PU_WIDTH_NBITS,
  parameter int TIMEOUT_NBITS = 10,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic core_req,
  input  logic core_wr,
  input  logic core_atomic,
  input  logic [4:0] core_funct5,
  input  logic [TID_NBITS-1:0] core_tid,
  input  logic [ADDR_NBITS-1:0] core_addr,
  input  logic [WIDTH_NBITS-1:0] core_wdata,
  output logic core_ready,
  output logic core_rsp_valid,
  output logic [WIDTH_NBITS-1:0] core_rsp_data,
  output logic core_rsp_err,
  output logic io_req,
  output io_type io_cmd,
  input  logic io_ack,
  input  logic [WIDTH_NBITS-1:0] io_ack_data,
  output logic stray_ack
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t state, state_nx;
  logic [TIMEOUT_NBITS-1:0] timer, timer_nx;
  logic rsp_valid_nx, rsp_err_nx, hit_to;
  logic [WIDTH_NBITS-1:0] rsp_data_nx;
  assign core_ready = state == IDLE;
  assign hit_to = timer == TIMEOUT_NBITS'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_nx = state;
    timer_nx = &timer ? timer : timer + 1'b1;
    rsp_valid_nx = 1'b0;
    rsp_err_nx = 1'b0;
    rsp_data_nx = '0;
    case (state)
      IDLE: state_nx = core_req ? ISSUE : IDLE;
      ISSUE: begin
        state_nx = WAIT;
        timer_nx = '0;
      end
      WAIT: begin
        // An ack on the timeout cycle takes priority over the error.
        if (io_ack) begin
          state_nx = IDLE;
          rsp_valid_nx = 1'b1;
          rsp_data_nx = (io_cmd.wr && !io_cmd.atomic) ? '0 : io_ack_data;
        end else if (hit_to) begin
          state_nx = DRAIN;
          timer_nx = '0;
          rsp_valid_nx = 1'b1;
          rsp_err_nx = 1'b1;
        end
      end
      DRAIN: state_nx = (io_ack || hit_to) ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      io_cmd <= '0;
      io_req <= 1'b0;
      core_rsp_valid <= 1'b0;
      core_rsp_err <= 1'b0;
      core_rsp_data <= '0;
      stray_ack <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      io_req <= core_ready && core_req;
      core_rsp_valid <= rsp_valid_nx;
      core_rsp_err <= rsp_err_nx;
      core_rsp_data <= rsp_data_nx;
      stray_ack <= stray_ack || (io_ack && (state == IDLE || state == ISSUE));
      if (core_ready && core_req)
        io_cmd <= '{tid: core_tid, addr: core_addr, wdata: core_wdata, wr: core_wr,
                    atomic: core_atomic, funct5: core_funct5};
    end
  end
endmodule

// File: tb/tb_pu_io_initiator.sv
// tb_pu_io_initiator: timestamp-based reference model plus directed literal checks.
module tb_pu_io_initiator;
  import pu_io_pkg::*;
  localparam int W = PU_WIDTH_NBITS;
  localparam int TO = 8;
  logic clk = 0, rst = 1;
  logic core_req = 0, core_wr = 0, core_atomic = 0;
  logic [4:0] core_funct5 = 0;
  logic [TID_NBITS-1:0] core_tid = 0;
  logic [ADDR_NBITS-1:0] core_addr = 0;
  logic [W-1:0] core_wdata = 0, io_ack_data = 0;
  logic io_ack = 0;
  logic core_ready, core_rsp_valid, core_rsp_err, io_req, stray_ack;
  logic [W-1:0] core_rsp_data;
  io_type io_cmd;
  int tests = 0, fails = 0;
  bit chk_on = 0;
  pu_io_initiator #(.WIDTH_NBITS(W), .TIMEOUT_NBITS(10), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .core_req(core_req), .core_wr(core_wr), .core_atomic(core_atomic),
    .core_funct5(core_funct5), .core_tid(core_tid), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ready(core_ready), .core_rsp_valid(core_rsp_valid),
    .core_rsp_data(core_rsp_data), .core_rsp_err(core_rsp_err), .io_req(io_req),
    .io_cmd(io_cmd), .io_ack(io_ack), .io_ack_data(io_ack_data), .stray_ack(stray_ack));
  always #5 clk = ~clk;
  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: transaction timestamps decide what each registered output must be.
  int cyc = 0, t_req = -100, t_drain = -100;
  bit busy = 0, draining = 0, m_req = 0, m_rv = 0, m_re = 0, m_stray = 0;
  logic [W-1:0] m_rd = 0;
  io_type m_cmd = '0;
  always @(posedge clk) begin
    m_req = 0; m_rv = 0; m_re = 0; m_rd = 0;
    if (rst) begin
      busy = 0; draining = 0; m_stray = 0; m_cmd = '0;
    end else begin
      if (io_ack && (!busy || cyc == t_req)) m_stray = 1;
      if (!busy) begin
        if (core_req) begin
          busy = 1; t_req = cyc + 1; m_req = 1;
          m_cmd = '{tid: core_tid, addr: core_addr, wdata: core_wdata, wr: core_wr,
                    atomic: core_atomic, funct5: core_funct5};
        end
      end else if (draining) begin
        if (io_ack || cyc == t_drain + TO - 1) begin busy = 0; draining = 0; end
      end else if (cyc > t_req) begin
        if (io_ack) begin
          busy = 0; m_rv = 1;
          m_rd = (m_cmd.wr && !m_cmd.atomic) ? '0 : io_ack_data;
        end else if (cyc == t_req + TO) begin
          m_rv = 1; m_re = 1; draining = 1; t_drain = cyc + 1;
        end
      end
    end
    cyc++;
  end
  always @(negedge clk) if (chk_on) begin
    chk("ready", 128'(core_ready), 128'(!busy));
    chk("io_req", 128'(io_req), 128'(m_req));
    chk("rsp_valid", 128'(core_rsp_valid), 128'(m_rv));
    chk("rsp_err", 128'(core_rsp_err), 128'(m_re));
    chk("rsp_data", 128'(core_rsp_data), 128'(m_rd));
    chk("stray", 128'(stray_ack), 128'(m_stray));
    chk("io_cmd", 128'(io_cmd), 128'(m_cmd));
  end
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic req(input logic wr, atomic, input logic [4:0] f5, input int tid, addr,
                     input logic [W-1:0] wdata);
    core_req = 1; core_wr = wr; core_atomic = atomic; core_funct5 = f5;
    core_tid = TID_NBITS'(tid); core_addr = ADDR_NBITS'(addr); core_wdata = wdata;
    tick;
    core_req = 0;
  endtask
  task automatic ack_after(input int n, input logic [W-1:0] d);
    repeat (n) tick;
    io_ack = 1; io_ack_data = d;
    tick;
    io_ack = 0;
  endtask
  initial begin
    repeat (2) tick;
    rst = 0; chk_on = 1;
    @(negedge clk);
    chk("reset_ready", 128'(core_ready), 128'(1));
    chk("reset_rsp", 128'({core_rsp_valid, core_rsp_err, io_req, stray_ack}), 128'(0));
    // read
    req(0, 0, 0, 2, 'h10, 0);
    @(negedge clk);
    chk("rd_io_req", 128'(io_req), 128'(1));
    chk("rd_tid", 128'(io_cmd.tid), 128'(2));
    chk("rd_wr", 128'(io_cmd.wr), 128'(0));
    ack_after(3, 'hA5);
    @(negedge clk);
    chk("rd_rsp", 128'({core_rsp_valid, core_rsp_err, core_rsp_data}), 128'({2'b10, 32'hA5}));
    // write, then back-to-back atomic on the response cycle
    req(1, 0, 0, 1, 'h20, 'h1234);
    @(negedge clk);
    chk("wr_wdata", 128'(io_cmd.wdata), 128'('h1234));
    chk("wr_wr", 128'(io_cmd.wr), 128'(1));
    ack_after(2, 'hFF);
    @(negedge clk);
    chk("wr_rsp", 128'({core_rsp_valid, core_rsp_err, core_rsp_data}), 128'({2'b10, 32'h0}));
    chk("wr_ready", 128'(core_ready), 128'(1));
    req(0, 1, 5'b00000, 3, 'h30, 5);
    @(negedge clk);
    chk("at_io_req", 128'(io_req), 128'(1));
    chk("at_flags", 128'({io_cmd.atomic, io_cmd.funct5}), 128'(6'b100000));
    ack_after(3, 7);
    @(negedge clk);
    chk("at_rsp", 128'({core_rsp_valid, core_rsp_err, core_rsp_data}), 128'({2'b10, 32'h7}));
    // timeout, then late ack in drain
    req(0, 0, 0, 4, 'h40, 0);
    repeat (8) tick;
    @(negedge clk);
    chk("to_early", 128'(core_rsp_valid), 128'(0));
    tick;
    @(negedge clk);
    chk("to_rsp", 128'({core_rsp_valid, core_rsp_err, core_rsp_data}), 128'({2'b11, 32'h0}));
    chk("to_ready", 128'(core_ready), 128'(0));
    ack_after(3, 'h99);
    @(negedge clk);
    chk("late_rsp", 128'(core_rsp_valid), 128'(0));
    chk("late_ready", 128'(core_ready), 128'(1));
    chk("late_stray", 128'(stray_ack), 128'(0));
    // ack on the exact timeout cycle wins
    req(0, 0, 0, 5, 'h50, 0);
    ack_after(8, 'h55);
    @(negedge clk);
    chk("edge_rsp", 128'({core_rsp_valid, core_rsp_err, core_rsp_data}), 128'({2'b10, 32'h55}));
    // second timeout returns silently
    req(0, 0, 0, 6, 'h60, 0);
    repeat (9) tick;
    repeat (7) tick;
    @(negedge clk);
    chk("drain_ready", 128'(core_ready), 128'(0));
    tick;
    @(negedge clk);
    chk("drain_done", 128'({core_ready, core_rsp_valid}), 128'(2'b10));
    // reset mid-WAIT, then late ack is stray
    req(0, 0, 0, 7, 'h70, 0);
    repeat (2) tick;
    rst = 1; tick; rst = 0;
    @(negedge clk);
    chk("rst_outs", 128'({io_req, core_rsp_valid, core_rsp_err, core_rsp_data, stray_ack, io_cmd}), 128'(0));
    chk("rst_ready", 128'(core_ready), 128'(1));
    ack_after(0, 'h11);
    @(negedge clk);
    chk("rst_stray", 128'({stray_ack, core_rsp_valid}), 128'(2'b10));
    rst = 1; tick; rst = 0;
    @(negedge clk);
    chk("stray_clr", 128'(stray_ack), 128'(0));
    // idle stray persists; a request while busy is ignored
    ack_after(0, 'h22);
    req(0, 0, 0, 1, 'h80, 0);
    tick;
    core_req = 1; core_tid = 9; tick; core_req = 0;
    ack_after(1, 'h3C);
    @(negedge clk);
    chk("sticky_rsp", 128'({core_rsp_valid, core_rsp_data}), 128'({1'b1, 32'h3C}));
    chk("sticky_stray", 128'(stray_ack), 128'(1));
    chk("ignored_tid", 128'(io_cmd.tid), 128'(1));
    repeat (3) tick;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
